// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue sequencer.
package alu_pkg;

   // ALU operation select encodings
   localparam logic [2:0] ALU_ROL = 3'b000;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_SRA = 3'b010;
   localparam logic [2:0] ALU_SRL = 3'b011;
   localparam logic [2:0] ALU_ADD = 3'b100;
   localparam logic [2:0] ALU_OR  = 3'b101;
   localparam logic [2:0] ALU_XOR = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b111;

   // Command codes accepted on in_cmd; 14 and 15 are illegal
   localparam logic [3:0] CMD_ADD  = 4'd0;
   localparam logic [3:0] CMD_SUB  = 4'd1;
   localparam logic [3:0] CMD_OR   = 4'd2;
   localparam logic [3:0] CMD_XOR  = 4'd3;
   localparam logic [3:0] CMD_ANDN = 4'd4;
   localparam logic [3:0] CMD_ROL  = 4'd5;
   localparam logic [3:0] CMD_SLL  = 4'd6;
   localparam logic [3:0] CMD_SRA  = 4'd7;
   localparam logic [3:0] CMD_SRL  = 4'd8;
   localparam logic [3:0] CMD_ROR  = 4'd9;
   localparam logic [3:0] CMD_SEQ  = 4'd10;
   localparam logic [3:0] CMD_SLT  = 4'd11;
   localparam logic [3:0] CMD_SLE  = 4'd12;
   localparam logic [3:0] CMD_SCO  = 4'd13;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_EXEC = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // How the write-back value and error flag are formed from the ALU flags
   typedef enum logic [2:0] {
      RES_OUT     = 3'd0,  // ALU Out, no error
      RES_OUT_OFL = 3'd1,  // ALU Out, error = Ofl (signed ADD/SUB)
      RES_ZERO    = 3'd2,  // set-on-equal
      RES_NEG     = 3'd3,  // set-on-less-than
      RES_LE      = 3'd4,  // set-on-less-or-equal
      RES_COUT    = 3'd5,  // set-on-carry-out
      RES_ILLEGAL = 3'd6   // zero result, error raised
   } res_sel_t;

endpackage

// File: rtl/alu_cmd_decode.sv
// Combinational translation of a command code into ALU control settings.
module alu_cmd_decode
   import alu_pkg::*;
(
   input  logic [3:0] in_cmd,
   input  logic       in_signed,
   output logic [2:0] op,
   output logic       inv_a,
   output logic       inv_b,
   output logic       cin,
   output logic       sign,
   output logic       two_pass,
   output res_sel_t   result_sel
);

   // Map each command to its ALU controls and result formation
   always_comb begin
      op         = ALU_AND;
      inv_a      = 1'b0;
      inv_b      = 1'b0;
      cin        = 1'b0;
      sign       = 1'b0;
      two_pass   = 1'b0;
      result_sel = RES_OUT;
      case (in_cmd)
         CMD_ADD: begin
            op         = ALU_ADD;
            sign       = in_signed;
            result_sel = in_signed ? RES_OUT_OFL : RES_OUT;
         end
         CMD_SUB: begin
            op         = ALU_ADD;
            inv_b      = 1'b1;
            cin        = 1'b1;
            sign       = in_signed;
            result_sel = in_signed ? RES_OUT_OFL : RES_OUT;
         end
         CMD_OR:   op = ALU_OR;
         CMD_XOR:  op = ALU_XOR;
         CMD_ANDN: begin
            op    = ALU_AND;
            inv_b = 1'b1;
         end
         CMD_ROL:  op = ALU_ROL;
         CMD_SLL:  op = ALU_SLL;
         CMD_SRA:  op = ALU_SRA;
         CMD_SRL:  op = ALU_SRL;
         CMD_ROR: begin
            // second pass is a left rotate by the negated count
            op       = ALU_ROL;
            two_pass = 1'b1;
         end
         CMD_SEQ: begin
            op         = ALU_ADD;
            inv_b      = 1'b1;
            cin        = 1'b1;
            result_sel = RES_ZERO;
         end
         CMD_SLT: begin
            op         = ALU_ADD;
            inv_b      = 1'b1;
            cin        = 1'b1;
            sign       = 1'b1;
            result_sel = RES_NEG;
         end
         CMD_SLE: begin
            op         = ALU_ADD;
            inv_b      = 1'b1;
            cin        = 1'b1;
            sign       = 1'b1;
            result_sel = RES_LE;
         end
         CMD_SCO: begin
            op         = ALU_ADD;
            result_sel = RES_COUT;
         end
         default: begin
            op         = ALU_AND;
            result_sel = RES_ILLEGAL;
         end
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the 16-bit execute-stage ALU: drives registered
// ALU controls, reads flags back and presents the write-back value.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_cmd,
   input  logic             in_signed,
   input  logic [WIDTH-1:0] in_rs,
   input  logic [WIDTH-1:0] in_rt,
   output logic [WIDTH-1:0] alu_InA,
   output logic [WIDTH-1:0] alu_InB,
   output logic             alu_Cin,
   output logic [2:0]       alu_Op,
   output logic             alu_invA,
   output logic             alu_invB,
   output logic             alu_sign,
   input  logic [WIDTH-1:0] alu_Out,
   input  logic             alu_Zero,
   input  logic             alu_Ofl,
   input  logic             alu_negative,
   input  logic             alu_Cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             ofl_err
);

   state_t           state;
   state_t           state_next;
   logic [2:0]       dec_op;
   logic             dec_inv_a;
   logic             dec_inv_b;
   logic             dec_cin;
   logic             dec_sign;
   logic             dec_two_pass;
   res_sel_t         dec_sel;
   res_sel_t         sel_hold;
   logic [WIDTH-1:0] rs_hold;

   alu_cmd_decode u_decode (
      .in_cmd     (in_cmd),
      .in_signed  (in_signed),
      .op         (dec_op),
      .inv_a      (dec_inv_a),
      .inv_b      (dec_inv_b),
      .cin        (dec_cin),
      .sign       (dec_sign),
      .two_pass   (dec_two_pass),
      .result_sel (dec_sel)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: accept in IDLE, optional negate pass, execute, hold until taken
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               state_next = dec_two_pass ? ST_PREP : ST_EXEC;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_PREP: state_next = ST_EXEC;
         ST_EXEC: state_next = ST_DONE;
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_DONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Handshake flags registered from the next state so they align with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         in_ready  <= (state_next == ST_IDLE);
         out_valid <= (state_next == ST_DONE);
      end
   end

   // ALU control registers, operand latch and write-back capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_InA  <= '0;
         alu_InB  <= '0;
         alu_Cin  <= 1'b0;
         alu_Op   <= 3'b000;
         alu_invA <= 1'b0;
         alu_invB <= 1'b0;
         alu_sign <= 1'b0;
         rs_hold  <= '0;
         sel_hold <= RES_OUT;
         result   <= '0;
         ofl_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  rs_hold  <= in_rs;
                  sel_hold <= dec_sel;
                  if (dec_two_pass) begin
                     // first pass computes -rt = ~rt + 1
                     alu_InA  <= in_rt;
                     alu_InB  <= '0;
                     alu_Cin  <= 1'b1;
                     alu_Op   <= ALU_ADD;
                     alu_invA <= 1'b1;
                     alu_invB <= 1'b0;
                     alu_sign <= 1'b0;
                  end else begin
                     alu_InA  <= in_rs;
                     alu_InB  <= in_rt;
                     alu_Cin  <= dec_cin;
                     alu_Op   <= dec_op;
                     alu_invA <= dec_inv_a;
                     alu_invB <= dec_inv_b;
                     alu_sign <= dec_sign;
                  end
               end else begin
                  rs_hold <= rs_hold;
               end
            end
            ST_PREP: begin
               // rotate right by n equals rotate left by (-n) mod 16
               alu_InA  <= rs_hold;
               alu_InB  <= {{(WIDTH-4){1'b0}}, alu_Out[3:0]};
               alu_Cin  <= 1'b0;
               alu_Op   <= ALU_ROL;
               alu_invA <= 1'b0;
               alu_invB <= 1'b0;
               alu_sign <= 1'b0;
            end
            ST_EXEC: begin
               case (sel_hold)
                  RES_OUT: begin
                     result  <= alu_Out;
                     ofl_err <= 1'b0;
                  end
                  RES_OUT_OFL: begin
                     result  <= alu_Out;
                     ofl_err <= alu_Ofl;
                  end
                  RES_ZERO: begin
                     result  <= {{(WIDTH-1){1'b0}}, alu_Zero};
                     ofl_err <= 1'b0;
                  end
                  RES_NEG: begin
                     result  <= {{(WIDTH-1){1'b0}}, alu_negative};
                     ofl_err <= 1'b0;
                  end
                  RES_LE: begin
                     result  <= {{(WIDTH-1){1'b0}}, alu_negative | alu_Zero};
                     ofl_err <= 1'b0;
                  end
                  RES_COUT: begin
                     result  <= {{(WIDTH-1){1'b0}}, alu_Cout};
                     ofl_err <= 1'b0;
                  end
                  default: begin
                     result  <= '0;
                     ofl_err <= 1'b1;
                  end
               endcase
            end
            default: begin
               result  <= result;
               ofl_err <= ofl_err;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural ALU model.
module tb_alu_issue_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_cmd;
   logic        in_signed;
   logic [15:0] in_rs;
   logic [15:0] in_rt;
   logic [15:0] alu_InA;
   logic [15:0] alu_InB;
   logic        alu_Cin;
   logic [2:0]  alu_Op;
   logic        alu_invA;
   logic        alu_invB;
   logic        alu_sign;
   logic [15:0] alu_Out;
   logic        alu_Zero;
   logic        alu_Ofl;
   logic        alu_negative;
   logic        alu_Cout;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        ofl_err;

   int checks = 0;
   int errors = 0;

   alu_issue_ctrl #(.WIDTH(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_cmd       (in_cmd),
      .in_signed    (in_signed),
      .in_rs        (in_rs),
      .in_rt        (in_rt),
      .alu_InA      (alu_InA),
      .alu_InB      (alu_InB),
      .alu_Cin      (alu_Cin),
      .alu_Op       (alu_Op),
      .alu_invA     (alu_invA),
      .alu_invB     (alu_invB),
      .alu_sign     (alu_sign),
      .alu_Out      (alu_Out),
      .alu_Zero     (alu_Zero),
      .alu_Ofl      (alu_Ofl),
      .alu_negative (alu_negative),
      .alu_Cout     (alu_Cout),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .ofl_err      (ofl_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural 16-bit ALU answering the DUT's controls
   logic [15:0] a_e;
   logic [15:0] b_e;
   logic [16:0] sum;
   logic [31:0] rol_w;
   logic        ofl_raw;
   always_comb begin
      a_e     = alu_invA ? ~alu_InA : alu_InA;
      b_e     = alu_invB ? ~alu_InB : alu_InB;
      sum     = {1'b0, a_e} + {1'b0, b_e} + {16'h0000, alu_Cin};
      rol_w   = {a_e, a_e} << b_e[3:0];
      ofl_raw = (a_e[15] == b_e[15]) && (sum[15] != a_e[15]);
      case (alu_Op)
         3'b000:  alu_Out = rol_w[31:16];
         3'b001:  alu_Out = a_e << b_e[3:0];
         3'b010:  alu_Out = 16'($signed(a_e) >>> b_e[3:0]);
         3'b011:  alu_Out = a_e >> b_e[3:0];
         3'b100:  alu_Out = sum[15:0];
         3'b101:  alu_Out = a_e | b_e;
         3'b110:  alu_Out = a_e ^ b_e;
         default: alu_Out = a_e & b_e;
      endcase
      alu_Zero     = (alu_Out == 16'h0000);
      alu_Cout     = sum[16];
      alu_Ofl      = alu_sign & ofl_raw;
      alu_negative = sum[15] ^ ofl_raw;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op and check latency, result and return to IDLE.
   // hold = cycles to keep out_ready low in DONE; cnt = expected PREP count for ROR.
   task automatic do_op(input string tag, input logic [3:0] cmd, input logic sgn,
                        input logic [15:0] rs, input logic [15:0] rt, input logic two,
                        input logic [15:0] cnt, input logic [15:0] exp_res,
                        input logic exp_ofl, input int hold);
      int waited;
      waited = 0;
      while (in_ready !== 1'b1 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      chk({tag, "_ready"}, {15'h0, in_ready}, 16'h0001);
      @(negedge clk);
      in_valid  = 1'b1;
      in_cmd    = cmd;
      in_signed = sgn;
      in_rs     = rs;
      in_rt     = rt;
      @(posedge clk); #1;             // acceptance edge E
      in_valid = 1'b0;
      chk({tag, "_lat_e"}, {15'h0, out_valid}, 16'h0000);
      if (two) begin
         @(posedge clk); #1;
         chk({tag, "_lat_e1"}, {15'h0, out_valid}, 16'h0000);
         chk({tag, "_count"}, alu_InB, cnt);
      end
      @(posedge clk); #1;
      chk({tag, "_valid"}, {15'h0, out_valid}, 16'h0001);
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_ofl"}, {15'h0, ofl_err}, {15'h0, exp_ofl});
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;             // must be ignored while busy
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, {15'h0, out_valid}, 16'h0001);
         chk({tag, "_hold_result"}, result, exp_res);
         chk({tag, "_hold_ready"}, {15'h0, in_ready}, 16'h0000);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_exit_valid"}, {15'h0, out_valid}, 16'h0000);
      chk({tag, "_exit_ready"}, {15'h0, in_ready}, 16'h0001);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_cmd    = 4'd0;
      in_signed = 1'b0;
      in_rs     = 16'h0000;
      in_rt     = 16'h0000;
      out_ready = 1'b1;
      #12;
      chk("rst_in_ready", {15'h0, in_ready}, 16'h0001);
      chk("rst_out_valid", {15'h0, out_valid}, 16'h0000);
      chk("rst_result", result, 16'h0000);
      chk("rst_ofl", {15'h0, ofl_err}, 16'h0000);
      chk("rst_alu_ctl", {9'h0, alu_Cin, alu_Op, alu_invA, alu_invB, alu_sign}, 16'h0000);
      chk("rst_alu_a", alu_InA, 16'h0000);
      chk("rst_alu_b", alu_InB, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("add_ofl", 4'd0, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h0, 16'h8000, 1'b1, 0);
      do_op("sub", 4'd1, 1'b1, 16'h0005, 16'h0007, 1'b0, 16'h0, 16'hFFFE, 1'b0, 0);
      chk("sub_invB", {15'h0, alu_invB}, 16'h0001);
      chk("sub_cin", {15'h0, alu_Cin}, 16'h0001);
      chk("sub_op", {13'h0, alu_Op}, 16'h0004);
      do_op("slt", 4'd11, 1'b0, 16'h8000, 16'h0001, 1'b0, 16'h0, 16'h0001, 1'b0, 0);
      do_op("sle", 4'd12, 1'b0, 16'h1234, 16'h1234, 1'b0, 16'h0, 16'h0001, 1'b0, 0);
      do_op("seq", 4'd10, 1'b0, 16'h1234, 16'h1235, 1'b0, 16'h0, 16'h0000, 1'b0, 0);
      do_op("ror4", 4'd9, 1'b0, 16'h0001, 16'h0004, 1'b1, 16'h000C, 16'h1000, 1'b0, 0);
      do_op("ror0", 4'd9, 1'b0, 16'hABCD, 16'h0000, 1'b1, 16'h0000, 16'hABCD, 1'b0, 0);
      do_op("sra", 4'd7, 1'b0, 16'h8000, 16'h0003, 1'b0, 16'h0, 16'hF000, 1'b0, 0);
      do_op("sco", 4'd13, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0, 16'h0001, 1'b0, 0);
      do_op("illegal", 4'd15, 1'b0, 16'h1234, 16'h5678, 1'b0, 16'h0, 16'h0000, 1'b1, 0);
      do_op("andn", 4'd4, 1'b1, 16'hFF0F, 16'h0F0F, 1'b0, 16'h0, 16'hF000, 1'b0, 0);

      // backpressure: consumer stalls 5 cycles in DONE
      out_ready = 1'b0;
      do_op("bp_xor", 4'd3, 1'b0, 16'h00FF, 16'h0F0F, 1'b0, 16'h0, 16'h0FF0, 1'b0, 5);
      do_op("after_bp", 4'd0, 1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0, 16'h0003, 1'b0, 0);

      // reset pulse while EXEC is in flight
      @(negedge clk);
      in_valid  = 1'b1;
      in_cmd    = 4'd2;
      in_signed = 1'b0;
      in_rs     = 16'h1111;
      in_rt     = 16'h2222;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("mid_rst_out_valid", {15'h0, out_valid}, 16'h0000);
      chk("mid_rst_in_ready", {15'h0, in_ready}, 16'h0001);
      chk("mid_rst_alu_a", alu_InA, 16'h0000);
      chk("mid_rst_alu_b", alu_InB, 16'h0000);
      chk("mid_rst_alu_ctl", {9'h0, alu_Cin, alu_Op, alu_invA, alu_invB, alu_sign}, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_out_valid", {15'h0, out_valid}, 16'h0000);
      do_op("post_rst_or", 4'd2, 1'b0, 16'h1111, 16'h2222, 1'b0, 16'h0, 16'h3333, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
